// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - dispense sequencer: event FIFO feeding product/coin four-phase handshakes
// Optional ack timeout with FAULT recovery: define VEND_DISPENSER_TIMEOUT_EN.
module vend_dispenser #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out,
    input  logic [1:0] change,
    output logic       prod_req,
    input  logic       prod_ack,
    output logic       coin_req,
    input  logic       coin_ack,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] coins_paid,
    output logic       fault
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PROD_REQ,
        ST_PROD_REL,
        ST_COIN_REQ,
        ST_COIN_REL
`ifdef VEND_DISPENSER_TIMEOUT_EN
        , ST_FAULT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        ev_prod_q, ev_prod_d;
    logic [1:0]  ev_coins_q, ev_coins_d;
    logic        prod_req_q, prod_req_d;
    logic        coin_req_q, coin_req_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  coins_paid_q, coins_paid_d;
    logic        fifo_empty, fifo_full;
    logic        push_req, push_en, pop_en, coin_done;
    logic [2:0]  pop_data;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_req   = out || (change != 2'd0);
    assign pop_en     = (state_q == ST_IDLE) && !fifo_empty;
    assign push_en    = push_req && (!fifo_full || pop_en);
    assign pop_data   = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign coin_done  = (state_q == ST_COIN_REQ) && coin_ack;

    always_ff @(posedge clk) begin
        if (push_en) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {out, change};
    end

    always_comb begin
        ev_prod_d  = ev_prod_q;
        ev_coins_d = ev_coins_q;
        if (pop_en) begin
            {ev_prod_d, ev_coins_d} = pop_data;
        end else if (coin_done) begin
            ev_coins_d = ev_coins_q - 2'd1;
        end
        overflow_d   = overflow_q || (push_req && fifo_full && !pop_en);
        coins_paid_d = (coin_done && coins_paid_q != 8'hFF) ? coins_paid_q + 8'd1 : coins_paid_q;
    end

`ifdef VEND_DISPENSER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] timer_q, timer_d;
    logic       fault_q, fault_d;
    logic       hs_state;

    assign hs_state = (state_q == ST_PROD_REQ) || (state_q == ST_PROD_REL) ||
                      (state_q == ST_COIN_REQ) || (state_q == ST_COIN_REL);
    assign fault    = fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            fault_q <= fault_d;
        end
    end
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ev_prod_q    <= 1'b0;
            ev_coins_q   <= 2'd0;
            prod_req_q   <= 1'b0;
            coin_req_q   <= 1'b0;
            overflow_q   <= 1'b0;
            coins_paid_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            ev_prod_q    <= ev_prod_d;
            ev_coins_q   <= ev_coins_d;
            prod_req_q   <= prod_req_d;
            coin_req_q   <= coin_req_d;
            overflow_q   <= overflow_d;
            coins_paid_q <= coins_paid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:     state_d = ev_prod_q ? ST_PROD_REQ :
                                   (ev_coins_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
            ST_PROD_REQ: if (prod_ack) state_d = ST_PROD_REL;
            ST_PROD_REL: if (!prod_ack) state_d = (ev_coins_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
            ST_COIN_REQ: if (coin_ack) state_d = ST_COIN_REL;
            // Coin count was already decremented when the ack arrived.
            ST_COIN_REL: if (!coin_ack) state_d = (ev_coins_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
`ifdef VEND_DISPENSER_TIMEOUT_EN
            ST_FAULT:    if (!prod_ack && !coin_ack) state_d = ST_IDLE;
`endif
            default:     state_d = ST_IDLE;
        endcase
`ifdef VEND_DISPENSER_TIMEOUT_EN
        if (hs_state && state_d == state_q && timer_q == TMO_LAST) state_d = ST_FAULT;
        timer_d = (hs_state && state_d == state_q) ? timer_q + 8'd1 : 8'd0;
        fault_d = fault_q || (state_d == ST_FAULT);
`endif
    end

    always_comb begin
        prod_req_d = (state_d == ST_PROD_REQ);
        coin_req_d = (state_d == ST_COIN_REQ);
    end

    assign prod_req   = prod_req_q;
    assign coin_req   = coin_req_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow   = overflow_q;
    assign coins_paid = coins_paid_q;
endmodule
